// File: rtl/mc_controller.sv
// Multi-cycle sequencing controller for an RV32I subset (R/I ALU, lw, sw, beq, jal, lui).
// Steps each instruction through fetch/decode/execute/memory/writeback and traps on bad encodings.
module mc_controller #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_we,
   output logic             sel_pc_next,
   output logic             ir_we,
   output logic             sel_mem_addr,
   output logic             mem_re,
   output logic             mem_we,
   output logic             rf_we,
   output logic [2:0]       sel_ext,
   output logic [1:0]       sel_alu_src_a,
   output logic [1:0]       sel_alu_src_b,
   output logic [3:0]       alu_control,
   output logic [1:0]       sel_result,
   output logic             retire,
   output logic [CNT_W-1:0] instret,
   output logic             trap,
   output logic [3:0]       state
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_LUI      = 4'd11,
      S_TRAP     = 4'd12
   } state_t;

   state_t cur_state, next_state;

   // Only funct7[5] distinguishes SUB/SRA; the remaining bits are don't-care here.
   logic unused_funct7;
   assign unused_funct7 = ^{funct7[6], funct7[4:0]};

   function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return 4'b0010;
         3'b010:  return 4'b0011;
         3'b011:  return 4'b0100;
         3'b100:  return 4'b0101;
         3'b101:  return alt ? 4'b0111 : 4'b0110;
         3'b110:  return 4'b1000;
         default: return 4'b1001;
      endcase
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) cur_state <= S_FETCH;
      else     cur_state <= next_state;
   end

   always_ff @(posedge clk) begin
      if (rst)         instret <= '0;
      else if (retire) instret <= instret + CNT_W'(1);
   end

   // NOTE: every combinational output gets a default first so no latch is inferred on any path.
   always_comb begin
      next_state = cur_state;
      case (cur_state)
         S_FETCH:    if (mem_ready) next_state = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: next_state = S_MEMADR;
               OP_R:              next_state = S_EXECR;
               OP_I:              next_state = S_EXECI;
               OP_BR:             next_state = (funct3 == 3'b000) ? S_BEQ : S_TRAP;
               OP_JAL:            next_state = S_JAL;
               OP_LUI:            next_state = S_LUI;
               default:           next_state = S_TRAP;
            endcase
         end
         S_MEMADR:   next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
         S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
         S_EXECR, S_EXECI: next_state = S_ALUWB;
         S_MEMWB, S_ALUWB, S_BEQ, S_JAL, S_LUI: next_state = S_FETCH;
         S_TRAP:     next_state = S_TRAP;
         default:    next_state = S_FETCH;
      endcase
   end

   always_comb begin
      pc_we         = 1'b0;
      sel_pc_next   = 1'b0;
      ir_we         = 1'b0;
      sel_mem_addr  = 1'b0;
      mem_re        = 1'b0;
      mem_we        = 1'b0;
      rf_we         = 1'b0;
      sel_ext       = 3'b000;
      sel_alu_src_a = 2'b00;
      sel_alu_src_b = 2'b00;
      alu_control   = ALU_ADD;
      sel_result    = 2'b00;
      retire        = 1'b0;
      trap          = 1'b0;
      case (cur_state)
         S_FETCH: begin
            mem_re        = 1'b1;
            sel_alu_src_b = 2'b10;
            ir_we         = mem_ready;
            pc_we         = mem_ready;
         end
         S_DECODE: begin
            // ALUOut captures old_pc + imm so branch/jump targets are ready later.
            sel_alu_src_a = 2'b01;
            sel_alu_src_b = 2'b01;
            if (opcode == OP_BR)       sel_ext = 3'b010;
            else if (opcode == OP_JAL) sel_ext = 3'b011;
         end
         S_MEMADR: begin
            sel_alu_src_a = 2'b10;
            sel_alu_src_b = 2'b01;
            sel_ext       = (opcode == OP_STORE) ? 3'b001 : 3'b000;
         end
         S_MEMREAD: begin
            sel_mem_addr = 1'b1;
            mem_re       = 1'b1;
         end
         S_MEMWB: begin
            rf_we      = 1'b1;
            sel_result = 2'b01;
            retire     = 1'b1;
         end
         S_MEMWRITE: begin
            sel_mem_addr = 1'b1;
            mem_we       = 1'b1;
            retire       = mem_ready;
         end
         S_EXECR: begin
            sel_alu_src_a = 2'b10;
            alu_control   = alu_decode(funct3, funct7[5]);
         end
         S_EXECI: begin
            sel_alu_src_a = 2'b10;
            sel_alu_src_b = 2'b01;
            alu_control   = alu_decode(funct3, (funct3 == 3'b101) && funct7[5]);
         end
         S_ALUWB: begin
            rf_we  = 1'b1;
            retire = 1'b1;
         end
         S_BEQ: begin
            sel_alu_src_a = 2'b10;
            alu_control   = ALU_SUB;
            sel_pc_next   = 1'b1;
            pc_we         = zero;
            retire        = 1'b1;
         end
         S_JAL: begin
            rf_we       = 1'b1;
            sel_result  = 2'b10;
            pc_we       = 1'b1;
            sel_pc_next = 1'b1;
            retire      = 1'b1;
         end
         S_LUI: begin
            rf_we      = 1'b1;
            sel_ext    = 3'b100;
            sel_result = 2'b11;
            retire     = 1'b1;
         end
         S_TRAP:  trap = 1'b1;
         default: ;
      endcase
   end

   assign state = cur_state;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: phase-sequence reference model, per-cycle compare,
// randomized instruction stream with random memory waits, plus directed literal checks.
module tb_mc_controller;

   localparam logic [6:0] OP_LW = 7'h03, OP_SW = 7'h23, OP_R = 7'h33, OP_I = 7'h13,
                          OP_B = 7'h63, OP_JAL = 7'h6F, OP_LUI = 7'h37;

   localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4,
                  P_MEMWRITE = 5, P_EXECR = 6, P_EXECI = 7, P_ALUWB = 8, P_BEQ = 9,
                  P_JAL = 10, P_LUI = 11, P_TRAP = 12;

   typedef struct packed {
      logic [3:0] st;
      logic       pc_we, sel_pc_next, ir_we, sel_mem_addr, mem_re, mem_we, rf_we;
      logic [2:0] ext;
      logic [1:0] src_a, src_b;
      logic [3:0] alu;
      logic [1:0] res;
      logic       retire, trap;
   } outs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [6:0] opcode = '0, funct7 = '0;
   logic [2:0] funct3 = '0;
   logic zero = 1'b0, mem_ready = 1'b0;

   logic pc_we, sel_pc_next, ir_we, sel_mem_addr, mem_re, mem_we, rf_we, retire, trap;
   logic [2:0] sel_ext;
   logic [1:0] sel_alu_src_a, sel_alu_src_b, sel_result;
   logic [3:0] alu_control, state;
   logic [31:0] instret;

   logic pc_we4, sel_pc_next4, ir_we4, sel_mem_addr4, mem_re4, mem_we4, rf_we4, retire4, trap4;
   logic [2:0] sel_ext4;
   logic [1:0] sel_alu_src_a4, sel_alu_src_b4, sel_result4;
   logic [3:0] alu_control4, state4;
   logic [3:0] instret4;

   mc_controller dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7), .zero(zero),
      .mem_ready(mem_ready), .pc_we(pc_we), .sel_pc_next(sel_pc_next), .ir_we(ir_we),
      .sel_mem_addr(sel_mem_addr), .mem_re(mem_re), .mem_we(mem_we), .rf_we(rf_we),
      .sel_ext(sel_ext), .sel_alu_src_a(sel_alu_src_a), .sel_alu_src_b(sel_alu_src_b),
      .alu_control(alu_control), .sel_result(sel_result), .retire(retire),
      .instret(instret), .trap(trap), .state(state)
   );

   mc_controller #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7), .zero(zero),
      .mem_ready(mem_ready), .pc_we(pc_we4), .sel_pc_next(sel_pc_next4), .ir_we(ir_we4),
      .sel_mem_addr(sel_mem_addr4), .mem_re(mem_re4), .mem_we(mem_we4), .rf_we(rf_we4),
      .sel_ext(sel_ext4), .sel_alu_src_a(sel_alu_src_a4), .sel_alu_src_b(sel_alu_src_b4),
      .alu_control(alu_control4), .sel_result(sel_result4), .retire(retire4),
      .instret(instret4), .trap(trap4), .state(state4)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   logic        chk_en = 1'b0;
   outs_t       exp_o;
   logic [31:0] ret_cnt = '0;

   // Per-instruction observations used by the directed literal checks.
   int   n_cyc, rf_we_cnt, pc_we_cnt;
   logic [31:0] seq;
   logic [3:0]  last_alu;

   logic [6:0] cur_op, cur_f7;
   logic [2:0] cur_f3;
   logic       cur_z;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic alt);
      logic [3:0] base [8];
      base = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
      if (alt && f3 == 3'd0) return 4'd1;
      if (alt && f3 == 3'd5) return 4'd7;
      return base[f3];
   endfunction

   function automatic outs_t model(input int p, input logic [6:0] op, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic z, input logic rdy);
      outs_t o;
      o = '0;
      o.st = 4'(p);
      case (p)
         P_FETCH:    begin o.mem_re = 1; o.src_b = 2; o.pc_we = rdy; o.ir_we = rdy; end
         P_DECODE:   begin
            o.src_a = 1; o.src_b = 1;
            o.ext = (op == OP_B) ? 3'd2 : (op == OP_JAL) ? 3'd3 : 3'd0;
         end
         P_MEMADR:   begin o.src_a = 2; o.src_b = 1; o.ext = (op == OP_SW) ? 3'd1 : 3'd0; end
         P_MEMREAD:  begin o.sel_mem_addr = 1; o.mem_re = 1; end
         P_MEMWB:    begin o.rf_we = 1; o.res = 1; o.retire = 1; end
         P_MEMWRITE: begin o.sel_mem_addr = 1; o.mem_we = 1; o.retire = rdy; end
         P_EXECR:    begin o.src_a = 2; o.alu = alu_ref(f3, f7[5]); end
         P_EXECI:    begin o.src_a = 2; o.src_b = 1; o.alu = alu_ref(f3, f3 == 3'd5 && f7[5]); end
         P_ALUWB:    begin o.rf_we = 1; o.retire = 1; end
         P_BEQ:      begin o.src_a = 2; o.alu = 1; o.sel_pc_next = 1; o.pc_we = z; o.retire = 1; end
         P_JAL:      begin o.rf_we = 1; o.res = 2; o.pc_we = 1; o.sel_pc_next = 1; o.retire = 1; end
         P_LUI:      begin o.rf_we = 1; o.ext = 4; o.res = 3; o.retire = 1; end
         default:    o.trap = 1;
      endcase
      return o;
   endfunction

   // Single compare process: checks both instances against the model every checked cycle.
   always @(negedge clk) begin
      outs_t a, a4;
      if (chk_en) begin
         a  = {state, pc_we, sel_pc_next, ir_we, sel_mem_addr, mem_re, mem_we, rf_we, sel_ext,
               sel_alu_src_a, sel_alu_src_b, alu_control, sel_result, retire, trap};
         a4 = {state4, pc_we4, sel_pc_next4, ir_we4, sel_mem_addr4, mem_re4, mem_we4, rf_we4,
               sel_ext4, sel_alu_src_a4, sel_alu_src_b4, alu_control4, sel_result4, retire4, trap4};
         check("outputs", a, exp_o);
         check("outputs_w4", a4, exp_o);
         check("instret", instret, ret_cnt);
         check("instret_w4", instret4, ret_cnt[3:0]);
         n_cyc++;
         seq = {seq[27:0], state};
         if (rf_we) rf_we_cnt++;
         if (pc_we) pc_we_cnt++;
         if (state == 4'd6 || state == 4'd7) last_alu = alu_control;
      end
   end

   task automatic step(input int p, input logic rdy);
      if (p == P_FETCH) begin
         opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
      end else begin
         opcode = cur_op; funct3 = cur_f3; funct7 = cur_f7;
      end
      zero = (p == P_BEQ) ? cur_z : 1'($urandom);
      if (p == P_FETCH || p == P_MEMREAD || p == P_MEMWRITE) mem_ready = rdy;
      else                                                   mem_ready = 1'($urandom);
      exp_o  = model(p, opcode, funct3, funct7, zero, mem_ready);
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      if (exp_o.retire) ret_cnt = ret_cnt + 1;
   endtask

   task automatic begin_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic z);
      cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_z = z;
      n_cyc = 0; rf_we_cnt = 0; pc_we_cnt = 0; seq = '0; last_alu = 'x;
   endtask

   // Phase sequence derived from the instruction class and the requested memory waits.
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic z, input int fw, input int mw);
      begin_instr(op, f3, f7, z);
      repeat (fw) step(P_FETCH, 1'b0);
      step(P_FETCH, 1'b1);
      step(P_DECODE, 1'b0);
      case (op)
         OP_LW: begin
            step(P_MEMADR, 1'b0);
            repeat (mw) step(P_MEMREAD, 1'b0);
            step(P_MEMREAD, 1'b1);
            step(P_MEMWB, 1'b0);
         end
         OP_SW: begin
            step(P_MEMADR, 1'b0);
            repeat (mw) step(P_MEMWRITE, 1'b0);
            step(P_MEMWRITE, 1'b1);
         end
         OP_R:   begin step(P_EXECR, 1'b0); step(P_ALUWB, 1'b0); end
         OP_I:   begin step(P_EXECI, 1'b0); step(P_ALUWB, 1'b0); end
         OP_B:   if (f3 == 3'd0) step(P_BEQ, 1'b0); else repeat (10) step(P_TRAP, 1'b0);
         OP_JAL: step(P_JAL, 1'b0);
         OP_LUI: step(P_LUI, 1'b0);
         default: repeat (10) step(P_TRAP, 1'b0);
      endcase
   endtask

   task automatic do_reset();
      chk_en = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      ret_cnt = '0;
      check("rst_state", state, 4'd0);
      check("rst_instret", instret, 32'd0);
      check("rst_trap", trap, 1'b0);
   endtask

   task automatic run_random(input int n);
      logic [6:0] ops [7];
      logic [6:0] op;
      logic [2:0] f3;
      ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_B, OP_JAL, OP_LUI};
      for (int i = 0; i < n; i++) begin
         op = ops[$urandom_range(0, 6)];
         f3 = (op == OP_B) ? 3'd0 : 3'($urandom);
         run_instr(op, f3, 7'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      do_reset();

      // R-type SUB: states 0,1,6,8 then back to 0.
      run_instr(OP_R, 3'd0, 7'b0100000, 1'b0, 0, 0);
      check("sub_seq", seq[15:0], 16'h0168);
      check("sub_alu", last_alu, 4'b0001);
      check("sub_rf_we", rf_we_cnt, 1);
      check("sub_instret", instret, 32'd1);
      check("sub_state_after", state, 4'd0);

      // lw with 2 waits in FETCH and 2 in MEMREAD: 9 cycles, one writeback.
      run_instr(OP_LW, 3'd2, 7'd0, 1'b0, 2, 2);
      check("lw_cycles", n_cyc, 9);
      check("lw_rf_we", rf_we_cnt, 1);
      check("lw_instret", instret, 32'd2);

      run_instr(OP_B, 3'd0, 7'd0, 1'b1, 0, 0);
      check("beq_taken_cycles", n_cyc, 3);
      check("beq_taken_pc_we", pc_we_cnt, 2);
      run_instr(OP_B, 3'd0, 7'd0, 1'b0, 0, 0);
      check("beq_not_taken_cycles", n_cyc, 3);
      check("beq_not_taken_pc_we", pc_we_cnt, 1);

      run_instr(OP_JAL, 3'd0, 7'd0, 1'b0, 0, 0);
      run_instr(OP_LUI, 3'd0, 7'd0, 1'b0, 0, 0);
      check("jal_lui_instret", instret, 32'd6);

      run_instr(OP_SW, 3'd2, 7'd0, 1'b0, 1, 3);
      check("sw_cycles", n_cyc, 8);

      // Illegal opcode traps and stays there until reset.
      run_instr(7'b1111111, 3'd0, 7'd0, 1'b0, 0, 0);
      check("illegal_trap", trap, 1'b1);
      check("illegal_state", state, 4'd12);
      check("illegal_rf_we", rf_we_cnt, 0);
      do_reset();
      run_instr(OP_B, 3'd1, 7'd0, 1'b1, 0, 0);
      check("bne_trap", trap, 1'b1);
      check("bne_pc_we", pc_we_cnt, 1);
      do_reset();

      // Reset while lw waits in MEMREAD: aborted, no retire.
      begin_instr(OP_LW, 3'd2, 7'd0, 1'b0);
      step(P_FETCH, 1'b1);
      step(P_DECODE, 1'b0);
      step(P_MEMADR, 1'b0);
      step(P_MEMREAD, 1'b0);
      do_reset();
      run_instr(OP_I, 3'd5, 7'b0100000, 1'b0, 0, 0);
      check("srai_alu", last_alu, 4'b0111);
      check("after_abort_instret", instret, 32'd1);

      // 17 instructions: 4-bit counter wraps to 1.
      do_reset();
      run_random(17);
      check("wrap_instret4", instret4, 4'd1);
      check("wrap_instret32", instret, 32'd17);

      run_random(300);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle sequencing controller for the RV32I subset: R-type ALU ops, I-type ALU ops, lw, sw, beq, jal and lui. It sits beside the multi-cycle datapath (PC, IR, ALUOut and MDR registers, one shared instruction/data memory port) and steps each instruction through fetch, decode, execute, memory and writeback states. It handles the memory ready handshake, counts retired instructions and parks in a sticky trap state on an unsupported encoding.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.

- `clk`  in  1: single clock; all state changes on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `opcode`  in  7: IR[6:0]; valid from DECODE onward.
- `funct3`  in  3: IR[14:12].
- `funct7`  in  7: IR[31:25].
- `zero`  in  1: ALU zero flag, same cycle.
- `mem_ready`  in  1: memory completes the current read/write this cycle.
- `pc_we`  out  1: PC register load.
- `sel_pc_next`  out  1: 0 = live ALU result, 1 = ALUOut register.
- `ir_we`  out  1: IR (and old-PC) register load.
- `sel_mem_addr`  out  1: 0 = PC, 1 = ALUOut.
- `mem_re`  out  1: memory read request.
- `mem_we`  out  1: memory write request.
- `rf_we`  out  1: register file write enable.
- `sel_ext`  out  3: 000 I, 001 S, 010 B, 011 J, 100 U.
- `sel_alu_src_a`  out  2: 00 PC, 01 old PC, 10 rs1.
- `sel_alu_src_b`  out  2: 00 rs2, 01 immediate, 10 constant 4.
- `alu_control`  out  4: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND.
- `sel_result`  out  2: 00 ALUOut, 01 MDR, 10 PC (already PC+4), 11 immediate.
- `retire`  out  1: one-cycle pulse on an instruction's final cycle.
- `instret`  out  CNT_W: count of retired instructions.
- `trap`  out  1: sticky illegal-instruction flag.
- `state`  out  4: current state encoding, for debug.

## Operation
- States and encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10, LUI 11, TRAP 12.
- All outputs not listed for a state are 0. ALU defaults to ADD.
- FETCH:
  - Outputs: sel_mem_addr=0, mem_re=1, src_a=PC, src_b=4, sel_pc_next=0.
  - On mem_ready=1: ir_we=1, pc_we=1, go to DECODE.
  - On mem_ready=0: hold in FETCH with no PC or IR write.
- DECODE:
  - Outputs: src_a=old PC, src_b=imm, ADD. sel_ext is driven from the opcode (B for 1100011, J for 1101111, otherwise I), so ALUOut captures the branch/jump target.
  - Next state by opcode: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 with funct3=000 → BEQ; 1101111 → JAL; 0110111 → LUI; anything else → TRAP.
- MEMADR:
  - Outputs: src_a=rs1, src_b=imm, ADD. sel_ext=I for lw, S for sw.
  - Next: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: sel_mem_addr=1, mem_re=1. Stay until mem_ready=1, then go to MEMWB.
- MEMWB: rf_we=1, sel_result=01, retire. Next FETCH.
- MEMWRITE: sel_mem_addr=1, mem_we=1. Stay until mem_ready=1, then retire and go to FETCH.
- EXECR:
  - Outputs: src_a=rs1, src_b=rs2.
  - alu_control from funct3: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND. funct7[5] selects SUB or SRA.
  - Next ALUWB.
- EXECI:
  - Outputs: src_a=rs1, src_b=imm, sel_ext=I.
  - Same funct3 decode as EXECR, except funct7[5] is consulted only when funct3=101.
  - Next ALUWB.
- ALUWB: rf_we=1, sel_result=00, retire. Next FETCH.
- BEQ: src_a=rs1, src_b=rs2, SUB, sel_pc_next=1, pc_we=zero, retire. Next FETCH.
- JAL: rf_we=1, sel_result=10, pc_we=1, sel_pc_next=1, retire. Next FETCH.
  - The RF write uses the pre-update PC (PC+4); the PC update lands on the same edge.
- LUI: rf_we=1, sel_ext=U, sel_result=11, retire. Next FETCH.
- TRAP: all enables 0, trap=1. Only rst exits.
- instret: increments by 1 each retire cycle and wraps modulo 2^CNT_W.

## Timing
- Reset: state=FETCH, instret=0, trap=0.
  - All state-decoded outputs therefore reflect FETCH in the first cycle after reset.
  - Reset mid-instruction, including a pending memory wait, aborts it with no retire.
- Outputs are combinational from state, opcode, funct3, funct7, zero and mem_ready. There are no registered outputs except state and instret.
- Cycles per instruction with zero-wait memory (each memory wait cycle adds 1):
  - beq, jal, lui: 3.
  - R-type, I-type, sw: 4.
  - lw: 5.
- mem_re and mem_we must remain asserted, with the address selection stable, until mem_ready is sampled high. Both are never high together.
- mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.
- instret is updated on the edge that ends the retire cycle. Its new value is visible the cycle after retire=1.

## Test plan
- Reset, then opcode=0110011, funct3=000, funct7=0100000 with mem_ready=1 → states 0,1,6,8,0; alu_control=0001 in EXECR; rf_we=1 only in ALUWB; instret=1.
- lw (0000011) with mem_ready low for 2 cycles in both FETCH and MEMREAD → 9 cycles total; mem_re held; single rf_we with sel_result=01.
- beq: zero=1 → pc_we=1 with sel_pc_next=1 in BEQ. Repeat with zero=0 → pc_we=0. Both retire, taking 3 cycles each.
- jal then lui → sel_ext 011 in DECODE and 100 in LUI; sel_result 10 and then 11; instret increments by 2.
- opcode=1111111, and separately beq with funct3=001 → TRAP after DECODE; trap=1; no enables over 10 cycles; rst returns to FETCH with trap=0.
- CNT_W=4: run 17 instructions → instret wraps to 1.
